// File: rtl/opr_microseq.sv
// rtl/opr_microseq.sv - operate-class micro-op sequencer; optional OSR via OPR_OSR_EN
module opr_microseq #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] inst,
  input  logic [W-1:0] acc_in,
  input  logic         link_in,
`ifdef OPR_OSR_EN
  input  logic [W-1:0] sr,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] acc_out,
  output logic         link_out,
  output logic         acc_we,
  output logic         link_we,
  output logic         skip,
  output logic         halt,
  output logic         illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_ILL,
    S_G1_CLR, S_G1_CMP, S_G1_IAC, S_G1_ROT1, S_G1_ROT2,
    S_G2_SKIP, S_G2_CLA, S_G2_OSR,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [7:0]   r_ops;
  logic [W-1:0] r_acc;
  logic         r_link;
  logic         r_grp2;
  logic         r_ill;
  logic         r_skip;
  logic         r_hlt;

  logic         w_bad_enc;
  logic [W:0]   w_inc;
  logic [W:0]   w_rot;
  logic [W-1:0] w_bsw;
  logic         w_cond;
  logic         w_ok;

  // Not an operate instruction, or group 3 (bit 8 and bit 0 both set).
  assign w_bad_enc = (inst[W-1:W-3] != 3'b111) | (inst[8] & inst[0]);
  // {L,AC} increment wraps at 13 bits so the carry toggles L.
  assign w_inc     = {r_link, r_acc} + {{W{1'b0}}, 1'b1};
  // Single rotate step through L; bit 3 selects right, otherwise left.
  assign w_rot     = r_ops[3] ? {r_acc[0], r_link, r_acc[W-1:1]}
                              : {r_acc[W-1], r_acc[W-2:0], r_link};
  assign w_bsw     = {r_acc[5:0], r_acc[W-1:6]};
  assign w_cond    = (r_ops[6] & r_acc[W-1]) | (r_ops[5] & (r_acc == '0)) | (r_ops[4] & r_link);

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state: fixed walk through every state of the selected group.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = w_bad_enc ? S_ILL : (inst[8] ? S_G2_SKIP : S_G1_CLR);
      S_ILL:     w_next = S_DONE;
      S_G1_CLR:  w_next = S_G1_CMP;
      S_G1_CMP:  w_next = S_G1_IAC;
      S_G1_IAC:  w_next = S_G1_ROT1;
      S_G1_ROT1: w_next = S_G1_ROT2;
      S_G1_ROT2: w_next = S_DONE;
      S_G2_SKIP: w_next = S_G2_CLA;
      S_G2_CLA:  w_next = S_G2_OSR;
      S_G2_OSR:  w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Working-copy datapath: each state applies its event-ordered micro-op.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ops  <= '0;
      r_acc  <= '0;
      r_link <= 1'b0;
      r_grp2 <= 1'b0;
      r_ill  <= 1'b0;
      r_skip <= 1'b0;
      r_hlt  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ops  <= inst[7:0];
            r_acc  <= acc_in;
            r_link <= link_in;
            r_grp2 <= inst[8] & ~w_bad_enc;
            r_ill  <= w_bad_enc;
            r_skip <= 1'b0;
            r_hlt  <= 1'b0;
          end
        end
        S_G1_CLR: begin
          if (r_ops[7]) r_acc  <= '0;
          if (r_ops[6]) r_link <= 1'b0;
        end
        S_G1_CMP: begin
          if (r_ops[5]) r_acc  <= ~r_acc;
          if (r_ops[4]) r_link <= ~r_link;
        end
        S_G1_IAC: begin
          if (r_ops[0]) {r_link, r_acc} <= w_inc;
        end
        S_G1_ROT1: begin
          if (r_ops[3] ^ r_ops[2])                   {r_link, r_acc} <= w_rot;
          else if (!r_ops[3] && !r_ops[2] && r_ops[1]) r_acc <= w_bsw;
        end
        S_G1_ROT2: begin
          if (r_ops[1] && (r_ops[3] ^ r_ops[2])) {r_link, r_acc} <= w_rot;
        end
        S_G2_SKIP: begin
          r_skip <= r_ops[3] ^ w_cond;
          r_hlt  <= r_ops[1];
        end
        S_G2_CLA: begin
          if (r_ops[7]) r_acc <= '0;
        end
`ifdef OPR_OSR_EN
        S_G2_OSR: begin
          if (r_ops[2]) r_acc <= r_acc | sr;
        end
`endif
        default: ;
      endcase
    end
  end

  // Outputs are quiet except in DONE; illegal encodings write nothing.
  always_comb begin
    busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    done     = (r_state == S_DONE);
    w_ok     = done & ~r_ill;
    acc_out  = w_ok ? r_acc : '0;
    link_out = w_ok & r_link;
    acc_we   = w_ok;
    link_we  = w_ok;
    skip     = done & r_grp2 & r_skip;
    halt     = done & r_grp2 & r_hlt;
    illegal  = done & r_ill;
  end

endmodule

// File: tb/tb_opr_microseq.sv
// tb/tb_opr_microseq.sv - directed self-checking bench for opr_microseq
module tb_opr_microseq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] inst = '0;
  logic [11:0] acc_in = '0;
  logic        link_in = 1'b0;
`ifdef OPR_OSR_EN
  logic [11:0] sr = '0;
`endif
  logic        busy, done, link_out, acc_we, link_we, skip, halt, illegal;
  logic [11:0] acc_out;

  int n_cmp = 0;
  int n_bad = 0;

  opr_microseq #(.W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .inst(inst), .acc_in(acc_in), .link_in(link_in),
`ifdef OPR_OSR_EN
    .sr(sr),
`endif
    .busy(busy), .done(done), .acc_out(acc_out), .link_out(link_out),
    .acc_we(acc_we), .link_we(link_we), .skip(skip), .halt(halt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_outs"}, {busy, done, acc_out, link_out, acc_we, link_we, skip, halt, illegal}, 32'd0);
  endtask

  // Issue one start pulse, then wait for done and check every result field.
  task automatic run_op(input string tag, input logic [11:0] ins, input logic [11:0] a,
                        input logic l, input logic [11:0] s, input int exp_lat,
                        input logic [11:0] eacc, input logic elink, input logic eskip,
                        input logic ehalt, input logic eill);
    int   lat;
    logic seen;
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    inst = ins; acc_in = a; link_in = l; start = 1'b1;
`ifdef OPR_OSR_EN
    sr = s;
`else
    if (s != 12'o0) lat = 0;
`endif
    @(posedge clk);
    #1;
    start = 1'b0; inst = 12'o0; acc_in = 12'(~a); link_in = ~l;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, "_busy"}, busy, 1'b1);
      if (done) begin
        seen = 1'b1;
        lat  = c;
        check({tag, "_lat"},  lat, exp_lat);
        check({tag, "_acc"},  acc_out, eill ? 12'o0 : eacc);
        check({tag, "_link"}, link_out, eill ? 1'b0 : elink);
        check({tag, "_we"},   {acc_we, link_we}, eill ? 2'b00 : 2'b11);
        check({tag, "_skip"}, skip, eskip);
        check({tag, "_halt"}, halt, ehalt);
        check({tag, "_ill"},  illegal, eill);
        check({tag, "_busy_at_done"}, busy, 1'b0);
      end
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int ndone;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset_idle");

    // Group 1
    run_op("cla_cll_iac", 12'o7301, 12'o5555, 1'b1, 12'o0, 6, 12'o0001, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("cma_iac",     12'o7041, 12'o0005, 1'b0, 12'o0, 6, 12'o7773, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("iac_wrap",    12'o7001, 12'o7777, 1'b1, 12'o0, 6, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("rtl",         12'o7006, 12'o4001, 1'b0, 12'o0, 6, 12'o0005, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("bsw",         12'o7002, 12'o0102, 1'b1, 12'o0, 6, 12'o0201, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("rar",         12'o7010, 12'o0001, 1'b0, 12'o0, 6, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("rar_ral_nop", 12'o7014, 12'o1234, 1'b1, 12'o0, 6, 12'o1234, 1'b1, 1'b0, 1'b0, 1'b0);

    // Group 2
    run_op("sza_cla_z",   12'o7640, 12'o0000, 1'b0, 12'o0, 4, 12'o0000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("sza_cla_nz",  12'o7640, 12'o0003, 1'b0, 12'o0, 4, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("spa_pos",     12'o7510, 12'o3777, 1'b0, 12'o0, 4, 12'o3777, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("spa_neg",     12'o7510, 12'o4000, 1'b0, 12'o0, 4, 12'o4000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("skp",         12'o7410, 12'o0042, 1'b1, 12'o0, 4, 12'o0042, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("hlt",         12'o7402, 12'o1234, 1'b1, 12'o0, 4, 12'o1234, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef OPR_OSR_EN
    run_op("osr",         12'o7404, 12'o0001, 1'b0, 12'o1234, 4, 12'o1235, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    run_op("osr_absent",  12'o7404, 12'o0001, 1'b0, 12'o1234, 4, 12'o0001, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Illegal encodings
    run_op("ill_opcode",  12'o1234, 12'o5555, 1'b1, 12'o0, 2, 12'o0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("ill_group3",  12'o7401, 12'o5555, 1'b1, 12'o0, 2, 12'o0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Start held/pulsed while busy is ignored
    @(negedge clk);
    inst = 12'o7301; acc_in = 12'o5555; link_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    inst = 12'o7041; acc_in = 12'o0005; link_in = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b0;
      if (done) begin
        ndone++;
        check("busy_ign_lat", c, 6);
        check("busy_ign_acc", acc_out, 12'o0001);
        check("busy_ign_link", link_out, 1'b0);
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("busy_ign_ndone", ndone, 1);

    // Reset at k+3 of a group 1 op
    @(negedge clk);
    inst = 12'o7301; acc_in = 12'o5555; link_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    rst = 1'b1;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("mid_reset_no_done", ndone, 0);

    // Normal operation resumes after the abandoned op
    run_op("after_reset", 12'o7041, 12'o0005, 1'b0, 12'o0, 6, 12'o7773, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/opr_microseq.md
Name: opr_microseq

Overview:
- Executes operate-class (opcode 111) microinstructions for the multicycle accumulator CPU.
- Sits downstream of the main controller's group-decode state. The controller pulses start with the fetched instruction and current AC/L, then waits for done.
- Performs PDP-8 style event-ordered micro-ops on private working copies of AC and L.
- Returns new AC/L with write strobes, plus a skip request (PC+2) and a halt request.

Parameters:
W, 12, accumulator/instruction width; only 12 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- inst  in  12  instruction word, sampled on accepted start.
- acc_in  in  12  current AC, sampled on accepted start.
- link_in  in  1  current L, sampled on accepted start.
- sr  in  12  front-panel switch register. Present only with OPR_OSR_EN.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- acc_out  out  12  result AC, valid while done=1.
- link_out  out  1  result L, valid while done=1.
- acc_we  out  1  AC write strobe, coincident with done.
- link_we  out  1  L write strobe, coincident with done.
- skip  out  1  PC+2 request, coincident with done.
- halt  out  1  halt request, coincident with done.
- illegal  out  1  unsupported encoding, coincident with done.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state goes to IDLE.
  - All outputs and working registers are 0.
  - An in-flight operation is abandoned with no done pulse.
- Acceptance:
  - start=1 in IDLE at edge k latches inst, acc_in and link_in.
  - start while busy is ignored; no queueing.
- Group select:
  - inst[11:9]!=111, or inst[8]=1 with inst[0]=1 (group 3): go to ILL; done at k+2 with illegal=1, all writes 0.
  - inst[8]=0: group 1.
  - inst[8]=1, inst[0]=0: group 2.
- Group 1 states, one cycle each; every state is always visited, so latency is fixed:
  - G1_CLR: inst[7] clears AC; inst[6] clears L.
  - G1_CMP: inst[5] complements AC; inst[4] complements L.
  - G1_IAC: if inst[0], {L,AC} <= {L,AC}+1, 13-bit wrap (carry out complements L; 7777/L=1 gives 0000/L=0).
  - G1_ROT1: apply one rotation step (rules below).
  - G1_ROT2: apply a second rotation step only if inst[1]=1 and exactly one of inst[3]/inst[2] is set.
  - DONE at k+6.
- Rotation rules (13-bit rotate through L):
  - inst[3] RAR: L<=AC[0], AC<={L,AC[11:1]}.
  - inst[2] RAL: L<=AC[11], AC<={AC[10:0],L}.
  - inst[3] and inst[2] both set: rotation is a no-op.
  - inst[1] with neither inst[3] nor inst[2]: BSW in ROT1, AC<={AC[5:0],AC[11:6]}, L unchanged; ROT2 is a no-op.
- Group 2 states; DONE at k+4:
  - G2_SKIP: evaluate on the latched AC/L. c = (inst[6]&AC[11]) | (inst[5]&(AC==0)) | (inst[4]&L). skip_r = inst[3] ? ~c : c, so inst[3] with no conditions gives an unconditional skip. HLT is recorded from inst[1].
  - G2_CLA: inst[7] clears AC.
  - G2_OSR: inst[2] ORs sr into AC (see Optional Feature).
- DONE (one cycle):
  - done=1, acc_we=1, link_we=1; acc_out/link_out driven from the working registers.
  - skip=skip_r and halt=hlt_r for group 2; both 0 for group 1.
  - Return to IDLE; busy drops in the same cycle.
  - A new start is accepted the following cycle.
- The caller must hold acc_in/link_in stable only during the start cycle.

Optional Feature:
- Macro: OPR_OSR_EN.
- Defined: the sr port exists, and G2_OSR performs AC<=AC|sr when inst[2]=1.
- Undefined: the sr port is absent, and G2_OSR is a no-op. Latency is unchanged (G2_OSR is still visited), and illegal stays 0 for OSR.

Test Plan:
- 7301 (CLA CLL IAC), AC=5555, L=1 -> done at k+6, AC=0001, L=0, skip=0.
- 7041 (CMA IAC), AC=0005, L=0 -> AC=7773, L=0. 7001 with AC=7777, L=1 -> AC=0000, L=0.
- 7006 (RTL), AC=4001, L=0 -> AC=0005, L=0. 7002 (BSW), AC=0102, L=1 -> AC=0201, L=1.
- 7640 (SZA CLA), AC=0000 -> skip=1, AC=0000, done at k+4. Same with AC=0003 -> skip=0, AC=0000.
- 7510 (SPA), AC=3777 -> skip=1; AC=4000 -> skip=0. 7402 (HLT) -> halt=1, AC unchanged.
- Misc: start with 1234 -> illegal=1 at k+2, no writes. Start pulses during busy -> ignored. rst=0 at k+3 of a group 1 op -> no done, all outputs 0. OPR_OSR_EN: 7404, sr=1234, AC=0001 -> AC=1235.
